// File: rtl/regn_pkg.sv
// regn_pkg: shared encodings for the universal register.
//   mode_e  : the eight synchronous operating modes (3 bits)
//   state_e : burst FSM states (2 bits)
//   DIR_L/DIR_R : shift direction constants
//   mode_dir() : serial-out direction implied by a mode
package regn_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_CLR  = 3'd6,
    MODE_INC  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // Right-moving modes present q[0] on so; everything else presents q[W-1].
  function automatic logic mode_dir(input logic [2:0] m);
    return ((m == MODE_SHR) || (m == MODE_ROR)) ? DIR_R : DIR_L;
  endfunction

endpackage

// File: rtl/regn_univ_shift_unit.sv
// shift_unit: combinational next-value generator for the register.
// Ports:
//   q   (in,  W) current register value
//   d   (in,  W) parallel load data
//   si  (in,  1) serial fill bit for SHL/SHR
//   op  (in,  3) operation, encoded as mode_e
//   q_n (out, W) next register value
module shift_unit
  import regn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  input  logic         si,
  input  logic [2:0]   op,
  output logic [W-1:0] q_n
);

  always_comb begin
    q_n = q;
    case (op)
      MODE_HOLD: q_n = q;
      MODE_LOAD: q_n = d;
      MODE_SHL:  q_n = {q[W-2:0], si};
      MODE_SHR:  q_n = {si, q[W-1:1]};
      MODE_ROL:  q_n = {q[W-2:0], q[W-1]};
      MODE_ROR:  q_n = {q[0], q[W-1:1]};
      MODE_CLR:  q_n = '0;
      MODE_INC:  q_n = q + W'(1);
      default:   q_n = q;
    endcase
  end

endmodule

// File: rtl/regn_univ.sv
// regn_univ: W-bit universal register with a self-timed burst shifter.
// Ports:
//   ck    (in)      rising-edge clock
//   rst   (in)      asynchronous active-high reset
//   mode  (in, 3)   operation, applied in IDLE/DONE
//   d     (in, W)   parallel load data
//   si    (in)      serial fill bit
//   start (in)      burst request, taken in IDLE only (wins over mode)
//   cnt   (in, CW)  burst length, taken with start
//   dir   (in)      burst direction, 0 = left, 1 = right, taken with start
//   q     (out, W)  register contents
//   so    (out)     serial out: q[W-1] when moving left, q[0] when moving right
//   busy  (out)     high during every SHIFT cycle
//   done  (out)     one-cycle pulse after a burst completes
// Valid/ready: there is no backpressure; start is a request that is
// accepted exactly when the FSM is in IDLE, and busy/done report progress.
// Internal FSM state is held in state_q for observation.
module regn_univ
  import regn_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [2:0]    mode,
  input  logic [W-1:0]  d,
  input  logic          si,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  input  logic          dir,
  output logic [W-1:0]  q,
  output logic          so,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [2:0]    su_op;
  logic [W-1:0]  su_q;

  // During a burst the shift unit runs the latched direction as a plain
  // shift with si fill; otherwise it runs whatever mode selects.
  always_comb begin
    su_op = mode;
    if (state_q == ST_SHIFT) begin
      su_op = (dir_q == DIR_R) ? MODE_SHR : MODE_SHL;
    end
  end

  shift_unit #(.W(W)) u_shift (
    .q   (q_q),
    .d   (d),
    .si  (si),
    .op  (su_op),
    .q_n (su_q)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Accepting a burst leaves q alone this edge.
          dir_d = dir;
          cnt_d = cnt;
          if (cnt != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          q_d = su_q;
        end
      end
      ST_SHIFT: begin
        q_d   = su_q;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        q_d     = su_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_L;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = busy_q;
  assign done = done_q;
  assign so   = (((state_q == ST_SHIFT) ? dir_q : mode_dir(mode)) == DIR_R)
                ? q_q[0] : q_q[W-1];

endmodule

// File: tb/tb_regn_univ.sv
module tb_regn_univ;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          ck = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          si;
  logic          start;
  logic [CW-1:0] cnt;
  logic          dir;
  logic [W-1:0]  q;
  logic          so;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 ck = ~ck;

  regn_univ #(.W(W), .CW(CW)) dut (
    .ck(ck), .rst(rst), .mode(mode), .d(d), .si(si), .start(start),
    .cnt(cnt), .dir(dir), .q(q), .so(so), .busy(busy), .done(done)
  );

  // ---------------- reference model ----------------
  // Burst bookkeeping: shifts still owed, and whether this cycle is the
  // one-cycle completion window.
  logic [W-1:0] m_q;
  int           m_left;
  bit           m_done;
  bit           m_dir;
  logic [W-1:0] exp_q[$];

  function automatic bit mdir(input logic [2:0] m);
    return (m == 3'd3 || m == 3'd5);
  endfunction

  task automatic model_reset();
    m_q = '0; m_left = 0; m_done = 0; m_dir = 0;
  endtask

  task automatic model_edge();
    int v;
    v = int'(m_q);
    if (m_left > 0) begin
      if (m_dir) v = (v >> 1) + (int'(si) << (W-1));
      else       v = ((v << 1) + int'(si)) % (1 << W);
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end else if (!m_done && start) begin
      m_dir  = dir;
      m_left = int'(cnt);
      m_done = (cnt == 0);
    end else begin
      m_done = 0;
      case (mode)
        3'd1: v = int'(d);
        3'd2: v = ((v << 1) + int'(si)) % (1 << W);
        3'd3: v = (v >> 1) + (int'(si) << (W-1));
        3'd4: v = ((v << 1) % (1 << W)) + (v >> (W-1));
        3'd5: v = (v >> 1) + ((v % 2) << (W-1));
        3'd6: v = 0;
        3'd7: v = (v + 1) % (1 << W);
        default: ;
      endcase
    end
    m_q = W'(v);
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [W-1:0] e;
    bit exp_so;
    e = exp_q.pop_front();
    exp_so = (m_left > 0) ? m_dir : mdir(mode);
    chk({tag, ".q"}, 32'(q), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".so"}, 32'(so), 32'(exp_so ? e[0] : e[W-1]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] m, input logic [W-1:0] dd, input logic s,
                       input logic st, input logic [CW-1:0] c, input logic dr);
    mode = m; d = dd; si = s; start = st; cnt = c; dir = dr;
  endtask

  task automatic cyc(input string tag);
    @(posedge ck);
    model_edge();
    exp_q.push_back(m_q);
    #1;
    chk_all(tag);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("arst.q", 32'(q), 32'(0));
    chk("arst.busy", 32'(busy), 32'(0));
    chk("arst.done", 32'(done), 32'(0));
    chk("arst.so", 32'(so), 32'(0));
    @(posedge ck);
    #3 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int busy_cycles;

  initial begin
    rst = 1'b1;
    drive(3'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    model_reset();
    #12;
    chk("rst.q", 32'(q), 32'(0));
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    rst = 1'b0;

    // load and hold
    drive(3'd1, 8'b00000011, 1'b0, 1'b0, '0, 1'b0); cyc("load");
    chk("load.const", 32'(q), 32'h03);
    drive(3'd0, 8'hEE, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("hold");
    chk("hold.const", 32'(q), 32'h03);

    // mid-run async reset
    async_reset();

    // single shifts
    drive(3'd1, 8'b00001111, 1'b0, 1'b0, '0, 1'b0); cyc("ld0f");
    drive(3'd2, 8'h00, 1'b1, 1'b0, '0, 1'b0); cyc("shl");
    chk("shl.const", 32'(q), 32'b00011111);
    drive(3'd3, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("shr");
    chk("shr.const", 32'(q), 32'b00001111);
    drive(3'd1, 8'b10000001, 1'b0, 1'b0, '0, 1'b0); cyc("ld81");
    drive(3'd4, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("rol");
    chk("rol.const", 32'(q), 32'b00000011);
    drive(3'd5, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("ror");
    chk("ror.const", 32'(q), 32'b10000001);

    // inc wrap and clear
    drive(3'd1, 8'hFF, 1'b0, 1'b0, '0, 1'b0); cyc("ldff");
    drive(3'd7, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("inc");
    chk("inc.wrap", 32'(q), 32'h00);
    drive(3'd1, 8'hA5, 1'b0, 1'b0, '0, 1'b0); cyc("lda5");
    drive(3'd6, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("clr");
    chk("clr.const", 32'(q), 32'h00);

    // burst right by 4, LOAD during busy must be ignored
    drive(3'd1, 8'b11110000, 1'b0, 1'b0, '0, 1'b0); cyc("ldf0");
    drive(3'd0, 8'h00, 1'b0, 1'b1, 4'd4, 1'b1); cyc("bst.start");
    busy_cycles = int'(busy);
    drive(3'd1, 8'h55, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc("bst.run");
      busy_cycles += int'(busy);
    end
    chk("bst.busycount", 32'(busy_cycles), 32'd4);
    chk("bst.q", 32'(q), 32'b00001111);
    chk("bst.done", 32'(done), 32'd1);
    drive(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("bst.after");
    chk("bst.after.done", 32'(done), 32'd0);
    chk("bst.after.busy", 32'(busy), 32'd0);

    // zero-length burst with LOAD presented alongside start
    drive(3'd1, 8'hAA, 1'b0, 1'b1, 4'd0, 1'b0); cyc("zlb");
    chk("zlb.q", 32'(q), 32'b00001111);
    chk("zlb.busy", 32'(busy), 32'd0);
    chk("zlb.done", 32'(done), 32'd1);
    drive(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("zlb.after");

    // back-to-back: start held through DONE
    drive(3'd0, 8'h00, 1'b1, 1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) cyc("b2b");
    drive(3'd0, 8'h00, 1'b0, 1'b0, '0, 1'b0); cyc("b2b.end");
    cyc("b2b.end2");

    // reset mid-burst
    drive(3'd0, 8'h00, 1'b1, 1'b1, 4'd6, 1'b0); cyc("rmb.start");
    drive(3'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    cyc("rmb.s1"); cyc("rmb.s2");
    async_reset();
    cyc("rmb.idle");
    chk("rmb.nodone", 32'(done), 32'd0);
    drive(3'd1, 8'h3C, 1'b0, 1'b0, '0, 1'b0); cyc("rmb.ld");
    drive(3'd0, 8'h00, 1'b1, 1'b1, 4'd2, 1'b1); cyc("rmb.b2");
    drive(3'd0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    cyc("rmb.b2s1"); cyc("rmb.b2s2");
    chk("rmb.b2.q", 32'(q), 32'hCF);
    chk("rmb.b2.done", 32'(done), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      cyc("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regn_univ.md
Name: regn_univ

Overview:
- Parametrised successor to the plain load register: a W-bit register with eight synchronous operating modes.
- Adds a self-timed burst shifter: on one start pulse it shifts the register by a programmed count while busy, then pulses done.
- Used as a general data register, serialiser or deserialiser next to the datapath; shares clock ck with the rest of the design.

Parameters:
W, 8, register width in bits (>=2)
CW, 4, burst counter width; max burst length 2^CW-1

Ports:
ck  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
mode  input  3  operation select (see Behaviour), sampled when not busy
d  input  W  parallel load data
si  input  1  serial input bit for shift modes and bursts
start  input  1  burst request, sampled in IDLE only
cnt  input  CW  burst length, sampled with start
dir  input  1  burst direction: 0 = shift left, 1 = shift right; sampled with start
q  output  W  register contents
so  output  1  serial out: q[W-1] when shifting left, q[0] when shifting right (combinational from q and active direction)
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Clock and reset: one clock ck. Reset rst is asynchronous and active-high.
- While rst is high: q=0, busy=0, done=0, internal counter=0, state=IDLE. so follows q, so it is 0.
- Modes apply on the rising edge of ck in IDLE or DONE:
  - 0 HOLD: q unchanged.
  - 1 LOAD: q<=d.
  - 2 SHL: q<={q[W-2:0],si}.
  - 3 SHR: q<={si,q[W-1:1]}.
  - 4 ROL: q<={q[W-2:0],q[W-1]}.
  - 5 ROR: q<={q[0],q[W-1:1]}.
  - 6 CLR: q<=0.
  - 7 INC: q<=q+1, modulo 2^W; wraps from all-ones to 0 with no flag.
- Direction for so:
  - In IDLE/DONE: direction is mode-derived (left for SHL/ROL, right for SHR/ROR, left otherwise).
  - In SHIFT: direction is the latched dir.
- FSM states are IDLE, SHIFT, DONE.
- IDLE:
  - start=1 takes priority over mode. mode is ignored that cycle, q unchanged, dir latched, counter<=cnt.
  - If cnt!=0, go to SHIFT; if cnt==0, go to DONE (no shift performed).
- SHIFT:
  - busy=1.
  - Each cycle: shift q one position in the latched direction with si as fill, then decrement the counter.
  - When the counter is 1 at the edge, perform the final shift and go to DONE.
  - A burst of cnt=N therefore occupies exactly N SHIFT cycles.
  - mode, start, cnt and dir are ignored.
- DONE:
  - busy=0 and done=1 for exactly one cycle, then go to IDLE.
  - mode operations are honoured; start is ignored.
- Latency:
  - Mode operations are visible on q one edge after sampling.
  - The start edge is followed by N shift edges; done is high in the cycle after the last shift.
- Back-to-back: a start held high through DONE is first accepted in the following IDLE cycle.
- Reset mid-burst: rst forces IDLE immediately; the burst is abandoned with no done pulse.
- Outputs q, busy and done are registered or state-decoded; there are no combinational paths from inputs to them.

Decomposition:
- Shared package regn_pkg holds:
  - Mode encodings: MODE_HOLD..MODE_INC.
  - FSM state encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Direction constants: DIR_L=0, DIR_R=1.
- One natural sub-module, shift_unit: combinational, parametrised W, takes q, si and a 3-bit op, and returns the next q for LOAD/SHL/SHR/ROL/ROR/CLR/INC/HOLD.
- The top level holds the FSM, the counter and the q register, and drives shift_unit with either mode or the burst op.

Test Plan:
- Reset and load: rst=1 mid-run -> q=0, busy=0, done=0 immediately, without waiting for a clock edge. Then mode=LOAD, d=8'b00000011 -> q=8'b00000011 after the next edge. HOLD for 3 cycles -> q unchanged.
- Single shifts on q=8'b00001111:
  - SHL si=1 -> 8'b00011111.
  - SHR si=0 -> back to 8'b00001111.
  - ROL on 8'b10000001 -> 8'b00000011.
  - ROR on 8'b00000011 -> 8'b10000001.
- INC wrap: q=8'hFF, mode=INC -> q=8'h00. CLR on 8'hA5 -> 8'h00.
- Burst right: q=8'b11110000, start=1, cnt=4, dir=1, si=0 -> busy=1 for exactly 4 cycles, q=8'b00001111, done high for one cycle, then busy=0 and done=0. A mode=LOAD applied during busy is ignored.
- Zero-length burst: start=1, cnt=0 -> q unchanged, busy never high, done pulses on the next cycle. Also apply start and mode=LOAD together in IDLE -> start wins and q is not loaded.
- Reset mid-burst: start cnt=6 dir=0, assert rst after 2 shifts -> q=0, state IDLE, no done pulse. After release, a new burst cnt=2 completes normally with done.
